line_render_sched: RTL and testbench
====================================

LINE_RENDER_SCHED -- requirements
Module: line_render_sched

Interface
REQ-001 SHALL provide parameter LINES, default 480: number of active lines rendered per frame.
REQ-002 SHALL provide parameter OVR_W, default 8: width of the overrun counter.
REQ-003 SHALL provide port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL provide port next_frame  input  1  one-cycle pulse, coincident with the next_line pulse that precedes line 0.
REQ-006 SHALL provide port next_line  input  1  one-cycle pulse at the end of each scan line.
REQ-007 SHALL provide ports l0_en, l1_en, spr_en  input  1 each  stage enables, sampled on line-start.
REQ-008 SHALL provide ports l0_done, l1_done, spr_done  input  1 each  stage-complete pulses from the renderers.
REQ-009 SHALL provide ports l0_start, l1_start, spr_start  output  1 each  one-cycle stage-start pulses.
REQ-010 SHALL provide port abort  output  1  one-cycle pulse; kills the in-flight stage.
REQ-011 SHALL provide port render_line  output  10  line currently being rendered.
REQ-012 SHALL provide port buf_sel  output  1  line buffer being written; the display side reads ~buf_sel.
REQ-013 SHALL provide port busy  output  1  high while any stage is in flight.
REQ-014 SHALL provide port overrun_cnt  output  OVR_W  saturating count of aborted lines.

Function
REQ-015 SHALL implement states IDLE, L0, L1, SPR; busy = (state != IDLE).
REQ-016 SHALL treat a cycle T with next_line=1 as a line event; all effects of the event appear at T+1.
REQ-017 At a line event, render_line SHALL become 0 if next_frame=1, else render_line+1 saturating at 1023.
REQ-018 At a line event, SHALL latch l0_en/l1_en/spr_en for the whole line.
REQ-019 At a line event, if the new render_line < LINES: SHALL toggle buf_sel and enter the first enabled stage in the order L0, L1, SPR, pulsing that stage's start in cycle T+1 only.
REQ-020 If the new render_line < LINES and no stage is enabled, SHALL toggle buf_sel and stay in IDLE.
REQ-021 If the new render_line >= LINES, SHALL stay in IDLE, issue no start pulse and leave buf_sel unchanged.
REQ-022 In stage X, SHALL ignore X_done in the cycle X_start is high.
REQ-023 In stage X, SHALL ignore done inputs of other stages.
REQ-024 On X_done at cycle D, SHALL enter the next latched-enabled stage at D+1 with its start pulse, else IDLE at D+1.
REQ-025 A line event while state != IDLE SHALL be an overrun, except when the current stage's done also arrives that cycle and it is the last enabled stage.
REQ-026 On an overrun, SHALL pulse abort at T+1 and increment overrun_cnt, holding at 2^OVR_W-1.
REQ-027 On an overrun, SHALL handle the new line per REQ-017..021 in the same T+1 cycle; abort and a new start may coincide.
REQ-028 When done for the last stage coincides with a line event, SHALL count no overrun, assert no abort and start the new line normally.
REQ-029 SHALL ignore next_frame without next_line.
REQ-030 Start pulses SHALL be mutually exclusive.
REQ-031 Start pulses SHALL never last more than one cycle.

Reset
REQ-032 While rst=1: state SHALL be IDLE; all start pulses, abort and busy SHALL be 0; buf_sel SHALL be 0; overrun_cnt SHALL be 0; render_line SHALL be 1023.
REQ-033 rst SHALL take priority over simultaneous next_line/done inputs.
REQ-034 rst asserted mid-line SHALL return to IDLE without an abort pulse.
REQ-035 After reset, no stage SHALL start until the first next_frame; line events before it keep render_line at 1023.

Verification
REQ-036 Reset, then next_line alone x3 -> render_line stays 1023, no starts, buf_sel=0.
REQ-037 next_frame+next_line with all enables=1, done 3 cycles after each start -> render_line=0, buf_sel=1, starts at T+1/T+5/T+9, busy low from T+13, overrun_cnt=0.
REQ-038 l0_en=0, l1_en=1, spr_en=0 -> only l1_start; IDLE the cycle after l1_done.
REQ-039 Withhold spr_done, then next_line -> abort at T+1, overrun_cnt=1, l0_start at T+1, buf_sel toggled.
REQ-040 spr_done coincident with next_line -> no abort, overrun_cnt unchanged.
REQ-041 Frame with 525 lines, LINES=480 -> exactly 480 l0_start pulses per frame.
REQ-042 Force 300 overruns with OVR_W=8 -> overrun_cnt holds 255.

Source files
------------

// File: rtl/line_render_sched.sv
// rtl/line_render_sched.sv - per-line render stage scheduler (L0 -> L1 -> SPR) with overrun abort
module line_render_sched #(
   parameter int LINES = 480,
   parameter int OVR_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             next_frame,
   input  logic             next_line,
   input  logic             l0_en,
   input  logic             l1_en,
   input  logic             spr_en,
   input  logic             l0_done,
   input  logic             l1_done,
   input  logic             spr_done,
   output logic             l0_start,
   output logic             l1_start,
   output logic             spr_start,
   output logic             abort,
   output logic [9:0]       render_line,
   output logic             buf_sel,
   output logic             busy,
   output logic [OVR_W-1:0] overrun_cnt
);

   typedef enum logic [1:0] {IDLE, L0, L1, SPR} state_t;

   localparam logic [10:0] LINES_W = 11'(LINES);

   state_t           state, state_n, after, go;
   logic [2:0]       en, en_n;
   logic [9:0]       line_n;
   logic             buf_n, cur_done, launch;
   logic [OVR_W-1:0] ovr_n;
   logic             l0s_n, l1s_n, sprs_n, abort_n;

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         en          <= 3'b000;
         render_line <= 10'h3ff;
         buf_sel     <= 1'b0;
         overrun_cnt <= '0;
         l0_start    <= 1'b0;
         l1_start    <= 1'b0;
         spr_start   <= 1'b0;
         abort       <= 1'b0;
      end else begin
         state       <= state_n;
         en          <= en_n;
         render_line <= line_n;
         buf_sel     <= buf_n;
         overrun_cnt <= ovr_n;
         l0_start    <= l0s_n;
         l1_start    <= l1s_n;
         spr_start   <= sprs_n;
         abort       <= abort_n;
      end
   end

   always_comb begin
      state_n  = state;
      en_n     = en;
      line_n   = render_line;
      buf_n    = buf_sel;
      ovr_n    = overrun_cnt;
      l0s_n    = 1'b0;
      l1s_n    = 1'b0;
      sprs_n   = 1'b0;
      abort_n  = 1'b0;
      cur_done = 1'b0;
      after    = IDLE;
      go       = IDLE;
      launch   = 1'b0;

      // a done in the same cycle as its own start belongs to the previous launch and is dropped
      case (state)
         L0: begin
            cur_done = l0_done & ~l0_start;
            after    = en[1] ? L1 : (en[2] ? SPR : IDLE);
         end
         L1: begin
            cur_done = l1_done & ~l1_start;
            after    = en[2] ? SPR : IDLE;
         end
         SPR: begin
            cur_done = spr_done & ~spr_start;
            after    = IDLE;
         end
         default: ;
      endcase

      if (next_line) begin
         if (state != IDLE && !(cur_done && after == IDLE)) begin
            abort_n = 1'b1;
            if (overrun_cnt != {OVR_W{1'b1}})
               ovr_n = overrun_cnt + {{(OVR_W-1){1'b0}}, 1'b1};
         end
         line_n = next_frame ? 10'd0 :
                  (render_line == 10'h3ff) ? render_line : render_line + 10'd1;
         en_n   = {spr_en, l1_en, l0_en};
         launch = 1'b1;
         if ({1'b0, line_n} < LINES_W) begin
            buf_n = ~buf_sel;
            go    = l0_en ? L0 : (l1_en ? L1 : (spr_en ? SPR : IDLE));
         end
      end else if (cur_done) begin
         launch = 1'b1;
         go     = after;
      end

      if (launch) begin
         state_n = go;
         l0s_n   = (go == L0);
         l1s_n   = (go == L1);
         sprs_n  = (go == SPR);
      end
   end

endmodule

// File: tb/tb_line_render_sched.sv
// tb/tb_line_render_sched.sv - self-checking bench for line_render_sched against a queue-based line model
module tb_line_render_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       next_frame = 1'b0, next_line = 1'b0;
   logic       l0_en = 1'b0, l1_en = 1'b0, spr_en = 1'b0;
   logic       l0_done = 1'b0, l1_done = 1'b0, spr_done = 1'b0;
   logic       l0_start, l1_start, spr_start, abort, buf_sel, busy;
   logic [9:0] render_line;
   logic [7:0] overrun_cnt;

   int checks = 0;
   int errors = 0;

   localparam logic [23:0] RST_VEC = {6'b000000, 10'd1023, 8'd0};

   line_render_sched #(.LINES(480), .OVR_W(8)) dut (
      .clk(clk), .rst(rst), .next_frame(next_frame), .next_line(next_line),
      .l0_en(l0_en), .l1_en(l1_en), .spr_en(spr_en),
      .l0_done(l0_done), .l1_done(l1_done), .spr_done(spr_done),
      .l0_start(l0_start), .l1_start(l1_start), .spr_start(spr_start),
      .abort(abort), .render_line(render_line), .buf_sel(buf_sel),
      .busy(busy), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   // model: the current stage plus a queue of stages still owed for this line (1=L0, 2=L1, 3=SPR)
   int m_line = 1023, m_ovr = 0, m_cur = 0;
   bit m_buf = 0, m_first = 0, m_abort = 0;
   bit m_s [3];
   int m_rem [$];

   task automatic model_clock();
      bit en [3];
      bit dn [3];
      bit cd, launch;
      en = '{l0_en, l1_en, spr_en};
      dn = '{l0_done, l1_done, spr_done};
      m_s = '{0, 0, 0};
      m_abort = 0;
      launch = 0;
      if (rst) begin
         m_line = 1023; m_buf = 0; m_ovr = 0; m_cur = 0; m_first = 0;
         m_rem.delete();
         return;
      end
      cd = (m_cur != 0) && !m_first && dn[m_cur-1];
      m_first = 0;
      if (next_line) begin
         if (m_cur != 0 && !(cd && m_rem.size() == 0)) begin
            m_abort = 1;
            if (m_ovr < 255) m_ovr++;
         end
         m_line = next_frame ? 0 : (m_line < 1023 ? m_line + 1 : 1023);
         m_cur = 0;
         m_rem.delete();
         if (m_line < 480) begin
            m_buf = !m_buf;
            for (int s = 0; s < 3; s++) if (en[s]) m_rem.push_back(s + 1);
         end
         launch = 1;
      end else if (cd) begin
         m_cur = 0;
         launch = 1;
      end
      if (launch && m_rem.size() > 0) begin
         m_cur = m_rem.pop_front();
         m_s[m_cur-1] = 1;
         m_first = 1;
      end
   endtask

   function automatic logic [23:0] exp_vec();
      return {m_s[0], m_s[1], m_s[2], m_abort, (m_cur != 0), m_buf, 10'(m_line), 8'(m_ovr)};
   endfunction

   function automatic logic [23:0] obs_vec();
      return {l0_start, l1_start, spr_start, abort, busy, buf_sel, render_line, overrun_cnt};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic clear_inputs();
      next_line = 0; next_frame = 0;
      l0_done = 0; l1_done = 0; spr_done = 0;
   endtask

   task automatic test_reset();
      rst = 1; next_line = 1; next_frame = 1; l0_en = 1; l0_done = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", obs_vec(), RST_VEC);
         end
      end
      rst = 0; clear_inputs(); l0_en = 0;
      tick();
   endtask

   task automatic test_pre_frame();
      l0_en = 1; l1_en = 1; spr_en = 1;
      for (int i = 0; i < 3; i++) begin
         next_line = 1;
         tick();
         next_line = 0;
         checks++;
         if (obs_vec() !== RST_VEC) begin
            errors++;
            $display("FAIL pre_frame_%0d obs=%h exp=%h", i, obs_vec(), RST_VEC);
         end
         tick();
      end
   endtask

   task automatic test_all_stages();
      l0_en = 1; l1_en = 1; spr_en = 1;
      next_frame = 1; next_line = 1;
      tick();
      clear_inputs();
      for (int k = 1; k <= 14; k++) begin
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL all_stages_k%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
         end
         if (k == 1 || k == 5 || k == 9) begin
            checks++;
            if ({l0_start, l1_start, spr_start} !== ((k == 1) ? 3'b100 : (k == 5) ? 3'b010 : 3'b001)) begin
               errors++;
               $display("FAIL start_timing_k%0d obs=%b", k, {l0_start, l1_start, spr_start});
            end
         end
         if (k == 13) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL busy_low_t13 obs=%b exp=0", busy);
            end
         end
         l0_done = (k == 4); l1_done = (k == 8); spr_done = (k == 12);
         tick();
      end
      clear_inputs();
      checks++;
      if ({render_line, buf_sel, overrun_cnt} !== {10'd0, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL frame_start obs=%0d/%b/%0d exp=0/1/0", render_line, buf_sel, overrun_cnt);
      end
   endtask

   task automatic test_l1_only();
      int n_l1 = 0, n_other = 0;
      l0_en = 0; l1_en = 1; spr_en = 0;
      next_line = 1;
      tick();
      clear_inputs();
      for (int k = 1; k <= 6; k++) begin
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL l1_only_k%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
         end
         n_l1 += l1_start;
         n_other += l0_start + spr_start;
         if (k == 2 || k == 4) begin
            checks++;
            if (busy !== (k == 2)) begin
               errors++;
               $display("FAIL l1_busy_k%0d obs=%b exp=%b", k, busy, k == 2);
            end
         end
         l1_done = (k == 1) || (k == 3);
         l0_done = (k == 1) || (k == 2);
         spr_done = (k == 2);
         tick();
      end
      clear_inputs();
      checks++;
      if (n_l1 != 1 || n_other != 0) begin
         errors++;
         $display("FAIL l1_only_starts l1=%0d other=%0d exp=1/0", n_l1, n_other);
      end
   endtask

   task automatic test_overrun();
      bit buf_before = 0;
      l0_en = 1; l1_en = 1; spr_en = 1;
      next_line = 1;
      tick();
      clear_inputs();
      for (int k = 1; k <= 9; k++) begin
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL overrun_k%0d obs=%h exp=%h", k, obs_vec(), exp_vec());
         end
         if (k == 9) begin
            checks++;
            if ({abort, overrun_cnt, l0_start, buf_sel} !== {1'b1, 8'd1, 1'b1, ~buf_before}) begin
               errors++;
               $display("FAIL overrun_effect obs=%b/%0d/%b/%b exp=1/1/1/%b",
                        abort, overrun_cnt, l0_start, buf_sel, ~buf_before);
            end
         end
         buf_before = m_buf;
         l0_done = (k == 2); l1_done = (k == 4); next_line = (k == 8);
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_done_coincide();
      for (int c = 10; c <= 16; c++) begin
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL coincide_c%0d obs=%h exp=%h", c, obs_vec(), exp_vec());
         end
         if (c == 15) begin
            checks++;
            if ({abort, overrun_cnt, l0_start} !== {1'b0, 8'd1, 1'b1}) begin
               errors++;
               $display("FAIL coincide_effect obs=%b/%0d/%b exp=0/1/1", abort, overrun_cnt, l0_start);
            end
         end
         l0_done = (c == 10); l1_done = (c == 12); spr_done = (c == 14); next_line = (c == 14);
         tick();
      end
      clear_inputs();
      for (int i = 0; i < 20; i++) begin
         l0_done = (m_cur == 1) && !m_first;
         l1_done = (m_cur == 2) && !m_first;
         spr_done = (m_cur == 3) && !m_first;
         tick();
      end
      clear_inputs();
   endtask

   task automatic test_frame_count();
      int n = 0;
      l0_en = 1; l1_en = 0; spr_en = 0;
      for (int ln = 0; ln < 525; ln++) begin
         next_line = 1; next_frame = (ln == 0);
         tick();
         clear_inputs();
         for (int j = 0; j < 5; j++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL frame_line%0d_j%0d obs=%h exp=%h", ln, j, obs_vec(), exp_vec());
            end
            n += l0_start;
            l0_done = (j == 1);
            tick();
         end
         l0_done = 0;
      end
      checks++;
      if (n != 480 || render_line !== 10'd524) begin
         errors++;
         $display("FAIL frame_count starts=%0d line=%0d exp=480/524", n, render_line);
      end
   endtask

   task automatic test_saturation();
      l0_en = 1; l1_en = 0; spr_en = 0;
      for (int i = 0; i < 310; i++) begin
         next_line = 1; next_frame = (i == 0);
         tick();
         clear_inputs();
         for (int j = 0; j < 2; j++) begin
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++;
               $display("FAIL sat_i%0d_j%0d obs=%h exp=%h", i, j, obs_vec(), exp_vec());
            end
            tick();
         end
      end
      checks++;
      if (overrun_cnt !== 8'd255) begin
         errors++;
         $display("FAIL overrun_saturate obs=%0d exp=255", overrun_cnt);
      end
   endtask

   task automatic test_random();
      int gap = 0, cdn = 0;
      for (int i = 0; i < 4000; i++) begin
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL random_cyc%0d obs=%h exp=%h", i, obs_vec(), exp_vec());
         end
         if (m_first) cdn = $urandom_range(0, 5);
         rst = ($urandom_range(0, 399) == 0);
         if (gap == 0) begin
            next_line = 1;
            next_frame = ($urandom_range(0, 29) == 0);
            gap = $urandom_range(3, 25);
         end else begin
            next_line = 0;
            next_frame = ($urandom_range(0, 9) == 0);
            gap--;
         end
         l0_en = ($urandom_range(0, 3) != 0);
         l1_en = ($urandom_range(0, 3) != 0);
         spr_en = ($urandom_range(0, 3) != 0);
         l0_done = ($urandom_range(0, 9) == 0);
         l1_done = ($urandom_range(0, 9) == 0);
         spr_done = ($urandom_range(0, 9) == 0);
         if (m_cur != 0 && !m_first) begin
            if (cdn == 0) begin
               case (m_cur)
                  1: l0_done = 1;
                  2: l1_done = 1;
                  default: spr_done = 1;
               endcase
            end else begin
               cdn--;
            end
         end
         tick();
      end
      rst = 0;
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_pre_frame();
      test_all_stages();
      test_l1_only();
      test_overrun();
      test_done_coincide();
      test_frame_count();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
